// File: rtl/sipo_loader_pkg.sv
// ============================================================================
// Module : aes_pkg
// Shared state encoding and default widths for the sipo_loader block buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int C_R_DATA_WIDTH_DEF = 32;
    localparam int C_N_REG_DEF        = 8;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_FILL = 2'd1;
    localparam logic [1:0] C_ST_FULL = 2'd2;

    typedef enum logic [1:0] {
        IDLE = C_ST_IDLE,
        FILL = C_ST_FILL,
        FULL = C_ST_FULL
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sipo_loader_mask.sv
// ============================================================================
// Module : sipo_mask
// Written-word mask register with popcount and next-cycle all-ones detect.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sipo_mask
    import aes_pkg::*;
#(
    parameter int N_REG      = C_N_REG_DEF,
    parameter int N_REG_BITS = (N_REG == 1) ? 1 : $clog2(N_REG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_set_en,
    input  logic [N_REG_BITS-1:0] i_set_idx,
    output logic [N_REG_BITS:0]   o_count,
    output logic                  o_next_full
);

    logic [N_REG-1:0] r_mask;
    logic [N_REG-1:0] w_set;
    logic [N_REG-1:0] w_mask_next;

    always_comb begin
        w_set = '0;
        for (int i = 0; i < N_REG; i++) begin
            w_set[i] = i_set_en && (i_set_idx == N_REG_BITS'(i));
        end
    end

    // A clear and a set in the same cycle leave only the newly set bit.
    assign w_mask_next = (i_clr ? '0 : r_mask) | w_set;
    assign o_next_full = &w_mask_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
        end else begin
            r_mask <= w_mask_next;
        end
    end

    always_comb begin
        o_count = '0;
        for (int i = 0; i < N_REG; i++) begin
            o_count = o_count + (N_REG_BITS + 1)'(r_mask[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sipo_loader.sv
// ============================================================================
// Module : sipo_loader
// Assembles addressed words into an N_REG-word block; optional write lock in
// FULL via SIPO_LOADER_LOCK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sipo_loader
    import aes_pkg::*;
#(
    parameter int R_DATA_WIDTH = C_R_DATA_WIDTH_DEF,
    parameter int N_REG        = C_N_REG_DEF,
    parameter int N_REG_BITS   = (N_REG == 1) ? 1 : $clog2(N_REG)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          write,
    input  logic [N_REG_BITS-1:0]         addr,
    input  logic [R_DATA_WIDTH-1:0]       din,
    input  logic                          consume,
    output logic [R_DATA_WIDTH*N_REG-1:0] dout,
    output logic                          full,
    output logic [N_REG_BITS:0]           count,
    output logic                          wr_err
);

    state_t r_state;
    state_t w_state_next;

    logic [R_DATA_WIDTH*N_REG-1:0] r_dout;
    logic                          r_wr_err;
    logic                          w_in_range;
    logic                          w_locked;
    logic                          w_consume;
    logic                          w_valid_wr;
    logic                          w_next_full;

    assign w_in_range = ({1'b0, addr} < (N_REG_BITS + 1)'(N_REG));
    assign w_consume  = consume && (r_state == FULL);

`ifdef SIPO_LOADER_LOCK_EN
    // A consume in the same cycle releases the lock before the write lands.
    assign w_locked = (r_state == FULL) && !consume;
`else
    assign w_locked = 1'b0;
`endif

    assign w_valid_wr = write && w_in_range && !w_locked && !clear;

    sipo_mask #(
        .N_REG      (N_REG),
        .N_REG_BITS (N_REG_BITS)
    ) u_mask (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (clear || w_consume),
        .i_set_en    (w_valid_wr),
        .i_set_idx   (addr),
        .o_count     (count),
        .o_next_full (w_next_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid_wr) begin
                        w_state_next = w_next_full ? FULL : FILL;
                    end
                end
                FILL: begin
                    if (w_valid_wr && w_next_full) begin
                        w_state_next = FULL;
                    end
                end
                FULL: begin
                    if (consume) begin
                        if (w_valid_wr) begin
                            w_state_next = w_next_full ? FULL : FILL;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < N_REG; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    r_dout[R_DATA_WIDTH*gi +: R_DATA_WIDTH] <= '0;
                end else if (w_valid_wr && (addr == N_REG_BITS'(gi))) begin
                    r_dout[R_DATA_WIDTH*gi +: R_DATA_WIDTH] <= din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= write && !clear && (!w_in_range || w_locked);
        end
    end

    assign dout   = r_dout;
    assign full   = (r_state == FULL);
    assign wr_err = r_wr_err;

endmodule

`default_nettype wire

// File: tb/tb_sipo_loader.sv
// ============================================================================
// Module : tb_sipo_loader
// Directed self-checking bench: 8-word and 6-word loaders share one stimulus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sipo_loader;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         write = 1'b0;
    logic [2:0]   addr = '0;
    logic [31:0]  din = '0;
    logic         consume = 1'b0;

    logic [255:0] dout8;
    logic         full8;
    logic [3:0]   count8;
    logic         wr_err8;
    logic [191:0] dout6;
    logic         full6;
    logic [3:0]   count6;
    logic         wr_err6;

    int n_chk  = 0;
    int n_pass = 0;

    sipo_loader #(.R_DATA_WIDTH(32), .N_REG(8)) u8 (
        .clk(clk), .rst(rst), .clear(clear), .write(write), .addr(addr),
        .din(din), .consume(consume), .dout(dout8), .full(full8),
        .count(count8), .wr_err(wr_err8)
    );

    sipo_loader #(.R_DATA_WIDTH(32), .N_REG(6)) u6 (
        .clk(clk), .rst(rst), .clear(clear), .write(write), .addr(addr),
        .din(din), .consume(consume), .dout(dout6), .full(full6),
        .count(count6), .wr_err(wr_err6)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic r, input logic c, input logic w, input logic [2:0] a,
                       input logic [31:0] d, input logic cons);
        rst = r; clear = c; write = w; addr = a; din = d; consume = cons;
        @(posedge clk);
        #1;
        rst = 1'b0; clear = 1'b0; write = 1'b0; addr = '0; din = '0; consume = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("reset_full",   full8,   0);
        chk("reset_count",  count8,  0);
        chk("reset_dout",   dout8,   0);
        chk("reset_wr_err", wr_err8, 0);

        // Fill 8-word block in order
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 3'(i), 32'h11111111 * i, 0);
        chk("fill7_count", count8, 7);
        chk("fill7_full",  full8,  0);
        cyc(0, 0, 1, 3'd7, 32'h77777777, 0);
        chk("fill8_full",  full8,  1);
        chk("fill8_count", count8, 8);
        chk("fill8_word0", dout8[31:0],    32'h0);
        chk("fill8_word7", dout8[255:224], 32'h77777777);

        // Write while FULL
        cyc(0, 0, 1, 3'd0, 32'hFFFFFFFF, 0);
`ifdef SIPO_LOADER_LOCK_EN
        chk("full_wr_err",  wr_err8,      1);
        chk("full_word0",   dout8[31:0],  32'h0);
`else
        chk("full_wr_err",  wr_err8,      0);
        chk("full_word0",   dout8[31:0],  32'hFFFFFFFF);
`endif
        chk("full_keep",    full8,        1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("full_wr_err_pulse", wr_err8, 0);

        // Consume and write together
        cyc(0, 0, 1, 3'd2, 32'hDEADBEEF, 1);
        chk("cw_full",  full8,  0);
        chk("cw_count", count8, 1);
        chk("cw_state", u8.r_state, FILL);
        chk("cw_word2", dout8[95:64],   32'hDEADBEEF);
        chk("cw_word7", dout8[255:224], 32'h77777777);

        cyc(0, 0, 0, 0, 0, 1);
        chk("consume_ignored_fill", count8, 1);

        // Clear, then rewrite one word twice
        cyc(0, 1, 0, 0, 0, 0);
        chk("clear_dout",  dout8,  0);
        chk("clear_count", count8, 0);
        cyc(0, 0, 1, 3'd3, 32'hAAAA5555, 0);
        cyc(0, 0, 1, 3'd3, 32'h12345678, 0);
        chk("rewrite_count", count8, 1);
        chk("rewrite_word3", dout8[127:96], 32'h12345678);
        chk("rewrite_full",  full8, 0);

        // Out-of-range address on the 6-word loader
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 3'd1, 32'h00000011, 0);
        cyc(0, 0, 1, 3'd7, 32'h00000BAD, 0);
        chk("oor_wr_err", wr_err6, 1);
        chk("oor_count",  count6,  1);
        chk("oor_dout",   dout6,   {160'h0, 32'h00000011, 32'h0});
        cyc(0, 0, 0, 0, 0, 0);
        chk("oor_wr_err_pulse", wr_err6, 0);

        // Six-word block completes while the eight-word one does not
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 3'(i), 32'h100 + i, 0);
        chk("n6_full",  full6,  1);
        chk("n6_count", count6, 6);
        chk("n8_partial_full", full8, 0);

        // Reset and clear mid-fill
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 3'(i), 32'h200 + i, 0);
        chk("pre_rst_count", count8, 5);
        cyc(1, 0, 1, 3'd5, 32'h55555555, 0);
        chk("rst_dout",   dout8,   0);
        chk("rst_count",  count8,  0);
        chk("rst_full",   full8,   0);
        chk("rst_wr_err", wr_err8, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 3'(i), 32'h300 + i, 0);
        chk("pre_clr_count", count8, 5);
        cyc(0, 1, 0, 0, 0, 1);
        chk("clr_dout",  dout8,  0);
        chk("clr_count", count8, 0);
        chk("clr_full",  full8,  0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sipo_loader.md
SIPO_LOADER -- requirements
Module: sipo_loader

Interface
REQ-001 SHALL have parameter R_DATA_WIDTH, default 32, the width of one input word.
REQ-002 SHALL have parameter N_REG, default 8, the number of words per block.
REQ-003 SHALL have parameter N_REG_BITS, default (N_REG==1) ? 1 : $clog2(N_REG), the address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port clear, input, 1 bit: synchronous flush of the block buffer.
REQ-007 SHALL have port write, input, 1 bit: word write strobe.
REQ-008 SHALL have port addr, input, N_REG_BITS bits: word index for a write.
REQ-009 SHALL have port din, input, R_DATA_WIDTH bits: the word to write.
REQ-010 SHALL have port consume, input, 1 bit: downstream has taken the block.
REQ-011 SHALL have port dout, output, R_DATA_WIDTH*N_REG bits: the assembled block; word i sits at bits [R_DATA_WIDTH*i +: R_DATA_WIDTH].
REQ-012 SHALL have port full, output, 1 bit: every word has been written since the last clear, consume or reset.
REQ-013 SHALL have port count, output, N_REG_BITS+1 bits: the number of distinct words written.
REQ-014 SHALL have port wr_err, output, 1 bit: one-cycle pulse on a rejected write.

Function
REQ-015 SHALL use states IDLE (mask all zero), FILL (mask partly set) and FULL (mask all ones).
REQ-016 SHALL register din into dout word addr on a valid write in IDLE or FILL, and set mask[addr].
REQ-017 SHALL ignore a write with addr >= N_REG: no data change, no mask change, wr_err pulse.
REQ-018 SHALL overwrite the data on a rewrite of an already-set word, leaving mask and count unchanged.
REQ-019 SHALL increment count only when a write sets a previously clear mask bit.
REQ-020 SHALL assert full in the cycle after the write that completes the mask (latency 1).
REQ-021 SHALL transition IDLE->FILL on the first valid write, FILL->FULL on mask completion, and FULL->IDLE on consume.
REQ-022 SHALL, when N_REG==1, go IDLE->FULL directly.
REQ-023 SHALL, on consume in FULL, clear mask, count and full next cycle while dout data is retained.
REQ-024 SHALL ignore consume outside FULL.
REQ-025 SHALL, on consume and a valid write in the same cycle in FULL, apply consume first, then the write: data written, mask = only that bit, count = 1, next state FILL.
REQ-026 SHALL, on clear, zero dout, mask, count and full and go to IDLE; clear has priority over write and consume.
REQ-027 SHALL never assert wr_err for more than one cycle per rejected write.

Reset
REQ-028 SHALL, while rst is high, set next cycle: state IDLE, dout=0, mask=0, count=0, full=0, wr_err=0.
REQ-029 SHALL give rst priority over clear, write and consume, including mid-fill; a partial block is discarded.

Configuration
REQ-030 SHALL implement macro SIPO_LOADER_LOCK_EN: when defined, writes in FULL are rejected (data unchanged) and pulse wr_err.
REQ-031 SHALL, with SIPO_LOADER_LOCK_EN undefined, overwrite data on writes in FULL, keep full=1, and pulse wr_err only for out-of-range addr.
REQ-032 SHALL apply REQ-025 in both configurations.

Structure
REQ-033 SHALL place state encoding (IDLE/FILL/FULL localparams) and the default widths in the shared package aes_pkg.
REQ-034 SHALL implement the mask-to-count/complete logic as the sub-module sipo_mask (mask register, popcount, all-ones detect).
REQ-035 SHALL size the block to feed the parallel-in/serial-out readback stage directly (same R_DATA_WIDTH/N_REG).

Verification
REQ-036 SHALL cover: N_REG=8; write words 0..7 = 0x00000000..0x77777777 in order -> full=1 one cycle after last write, count=8, dout[31:0]=0, dout[255:224]=0x77777777.
REQ-037 SHALL cover: write addr 3 twice (0xAAAA5555 then 0x12345678) -> count=1, word3=0x12345678, full=0.
REQ-038 SHALL cover: N_REG=6, write addr 7 -> wr_err pulses 1 cycle, count unchanged, dout unchanged.
REQ-039 SHALL cover: FULL, consume and write addr 2=0xDEADBEEF same cycle -> full=0, count=1, state FILL, word2=0xDEADBEEF.
REQ-040 SHALL cover: FULL, write addr 0=0xFFFFFFFF with LOCK_EN -> wr_err=1, word0 unchanged; without LOCK_EN -> word0=0xFFFFFFFF, wr_err=0, full=1.
REQ-041 SHALL cover: count=5 then rst for 1 cycle together with write -> dout=0, count=0, full=0; clear with consume -> same result.
